// File: rtl/prog_loader_if.sv
// Loader-side bundle: byte-stream handshake in, program-memory write port and status out.
// A byte moves on a rising edge where in_valid && in_ready; in_data must stay stable while in_valid waits.
interface prog_loader_if #(
  parameter int Psize = 5,
  parameter int Isize = 16
);
  logic             start;
  logic [Psize:0]   len;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             we;
  logic [Psize-1:0] waddr;
  logic [Isize-1:0] wdata;
  logic             busy;
  logic             done;

  modport master (
    output start, len, in_valid, in_data,
    input  in_ready, we, waddr, wdata, busy, done
  );

  modport slave (
    input  start, len, in_valid, in_data,
    output in_ready, we, waddr, wdata, busy, done
  );
endinterface

// File: rtl/prog_loader.sv
// Program-memory writer: packs an MSB-first byte stream into Isize-bit words and writes
// them to addresses 0..eff_len-1, holding the CPU off via busy while loading.
module prog_loader #(
  parameter int Psize = 5,
  parameter int Isize = 16
) (
  input  logic         clk,
  input  logic         nReset,
  prog_loader_if.slave bus,
  output logic [1:0]   dbg_state
);
  localparam int NB  = (Isize + 7) / 8;
  localparam int BW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int SRW = NB * 8;
  localparam logic [BW-1:0]  LAST_B = BW'(NB - 1);
  localparam logic [Psize:0] CAP    = {1'b1, {Psize{1'b0}}};

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  state_t           state, state_nxt;
  logic [Psize:0]   eff_len, wcnt;
  logic [Psize-1:0] addr, waddr_q;
  logic [BW-1:0]    bcnt;
  logic [SRW-1:0]   sr, sr_shift;
  logic [Isize-1:0] wdata_q;
  logic             last_byte;

  // Excess high bits of the first byte fall off here when Isize is not a multiple of 8.
  assign sr_shift  = SRW'({sr, bus.in_data});
  assign last_byte = bus.in_valid && (bcnt == LAST_B);

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.start) state_nxt = (bus.len == '0) ? DONE : RECV;
      RECV:  if (last_byte) state_nxt = WRITE;
      WRITE: state_nxt = ((wcnt + (Psize+1)'(1)) == eff_len) ? DONE : RECV;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = 1'b0;
    bus.we       = 1'b0;
    bus.busy     = 1'b1;
    bus.done     = 1'b0;
    case (state)
      IDLE:  bus.busy     = 1'b0;
      RECV:  bus.in_ready = 1'b1;
      WRITE: bus.we       = 1'b1;
      DONE:  bus.done     = 1'b1;
      default: bus.busy   = 1'b0;
    endcase
  end

  assign bus.waddr = waddr_q;
  assign bus.wdata = wdata_q;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      eff_len <= '0;
      wcnt    <= '0;
      addr    <= '0;
      bcnt    <= '0;
      sr      <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            eff_len <= (bus.len > CAP) ? CAP : bus.len;
            wcnt    <= '0;
            addr    <= '0;
            bcnt    <= '0;
            sr      <= '0;
          end
        end
        RECV: begin
          if (bus.in_valid) begin
            sr   <= sr_shift;
            bcnt <= bcnt + BW'(1);
          end
          // Register the write port on the last byte so it is valid for the whole WRITE cycle.
          if (last_byte) begin
            waddr_q <= addr;
            wdata_q <= sr_shift[Isize-1:0];
          end
        end
        WRITE: begin
          wcnt <= wcnt + (Psize+1)'(1);
          addr <= addr + Psize'(1);
          bcnt <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: expected writes are hand-computed and queued in exp_q,
// observed writes are collected by a negedge monitor and compared after each load.
module tb_prog_loader;
  localparam int Psize = 5;
  localparam int Isize = 16;

  logic       clk = 1'b0;
  logic       nReset = 1'b1;
  logic [1:0] dbg_state;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  int busy_cnt = 0;
  int t0;

  logic [20:0] exp_q[$];
  logic [20:0] obs_q[$];
  int          wcyc_q[$];
  int          done_q[$];
  logic [7:0]  stream_q[$];

  prog_loader_if #(.Psize(Psize), .Isize(Isize)) bus();

  prog_loader #(.Psize(Psize), .Isize(Isize)) dut (
    .clk       (clk),
    .nReset    (nReset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset-independent cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: cyc here equals the number of rising edges seen so far
  always @(negedge clk) begin
    if (nReset) begin
      if (bus.we) begin
        obs_q.push_back({bus.waddr, bus.wdata});
        wcyc_q.push_back(cyc);
      end
      if (bus.done) done_q.push_back(cyc);
      if (bus.busy) busy_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_we"},       32'(bus.we),       32'd0);
    check({tag, "_busy"},     32'(bus.busy),     32'd0);
    check({tag, "_done"},     32'(bus.done),     32'd0);
    check({tag, "_waddr"},    32'(bus.waddr),    32'd0);
    check({tag, "_wdata"},    32'(bus.wdata),    32'd0);
  endtask

  task automatic clear_obs();
    exp_q.delete();
    obs_q.delete();
    wcyc_q.delete();
    done_q.delete();
    stream_q.delete();
    busy_cnt = 0;
  endtask

  // Starts a load; returns T, the edge that accepts start. Ends at the negedge after T.
  task automatic do_start(input int l, output int t);
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = l[Psize:0];
    t = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // driver: pushes stream_q; with gaps, valid is random while ready and held high otherwise
  task automatic send_stream(input bit gaps);
    int  i = 0;
    int  guard = 0;
    logic acc;
    while (i < stream_q.size() && guard < 3000) begin
      bus.in_data  = stream_q[i];
      bus.in_valid = gaps ? (bus.in_ready ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b1;
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      if (acc) i++;
      @(negedge clk);
      guard++;
    end
    bus.in_valid = 1'b0;
    check("stream_drained", 32'(i), 32'(stream_q.size()));
  endtask

  task automatic wait_done();
    int g = 0;
    while (done_q.size() == 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check({tag, "_write"}, 32'(obs_q[i]), 32'(exp_q[i]));
  endtask

  task automatic load_capacity(input int l, input string tag);
    clear_obs();
    for (int i = 0; i < 64; i++) stream_q.push_back(8'(i));
    for (int a = 0; a < 32; a++) exp_q.push_back({5'(a), 8'(2*a), 8'(2*a + 1)});
    do_start(l, t0);
    send_stream(1'b0);
    wait_done();
    check_writes(tag);
    if (obs_q.size() > 0) begin
      check({tag, "_last_addr"}, 32'(obs_q[obs_q.size()-1][20:16]), 32'd31);
      check({tag, "_last_data"}, 32'(obs_q[obs_q.size()-1][15:0]), 32'h3E3F);
      check({tag, "_done_cnt"}, 32'(done_q.size()), 32'd1);
      if (done_q.size() > 0)
        check({tag, "_done_cyc"}, 32'(done_q[0]), 32'(wcyc_q[wcyc_q.size()-1] + 1));
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0; bus.in_data = '0;

    // reset with random inputs
    #1 nReset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      bus.start    = 1'($urandom_range(0, 1));
      bus.len      = (Psize+1)'($urandom_range(0, 63));
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data  = 8'($urandom_range(0, 255));
      #1 check_outputs_zero("reset");
    end

    // basic load: start presented on the negedge that releases reset
    clear_obs();
    stream_q = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01};
    exp_q    = '{{5'd0, 16'h1234}, {5'd1, 16'hABCD}, {5'd2, 16'h0001}};
    @(negedge clk);
    nReset = 1'b1;
    bus.start = 1'b1; bus.len = 6'd3; bus.in_valid = 1'b0;
    t0 = cyc + 1;
    @(negedge clk);
    bus.start = 1'b0;
    check("start_after_reset_busy", 32'(bus.busy), 32'd1);
    check("start_after_reset_state", 32'(dbg_state), 32'd1);
    send_stream(1'b0);
    wait_done();
    check_writes("basic");
    for (int i = 0; i < 3 && i < wcyc_q.size(); i++)
      check("basic_we_cyc", 32'(wcyc_q[i]), 32'(t0 + 2 + 3*i));
    check("basic_done_cnt", 32'(done_q.size()), 32'd1);
    if (done_q.size() > 0) check("basic_done_cyc", 32'(done_q[0]), 32'(t0 + 9));
    check("basic_busy_cycles", 32'(busy_cnt), 32'd10);

    // same stream with random valid gaps
    clear_obs();
    stream_q = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01};
    exp_q    = '{{5'd0, 16'h1234}, {5'd1, 16'hABCD}, {5'd2, 16'h0001}};
    do_start(3, t0);
    send_stream(1'b1);
    wait_done();
    check_writes("gaps");
    check("gaps_done_cnt", 32'(done_q.size()), 32'd1);

    // full capacity, then a length beyond capacity
    load_capacity(32, "cap32");
    load_capacity(40, "clamp40");

    // zero length: only the DONE cycle is non-IDLE
    clear_obs();
    do_start(0, t0);
    repeat (4) @(negedge clk);
    check("zero_we_count", 32'(obs_q.size()), 32'd0);
    check("zero_done_cnt", 32'(done_q.size()), 32'd1);
    if (done_q.size() > 0) check("zero_done_cyc", 32'(done_q[0]), 32'(t0));
    check("zero_busy_cycles", 32'(busy_cnt), 32'd1);

    // ignored start during RECV, then reset after 3 bytes of a 4-word load
    clear_obs();
    exp_q = '{{5'd0, 16'hA1A2}};
    do_start(4, t0);
    bus.in_valid = 1'b1; bus.in_data = 8'hA1;
    @(posedge clk); @(negedge clk);
    bus.in_data = 8'hA2; bus.start = 1'b1; bus.len = 6'd0;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    check("ignored_start_state", 32'(dbg_state), 32'd2);
    bus.in_data = 8'hB1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    check("midload_state_recv", 32'(dbg_state), 32'd1);
    nReset = 1'b0;
    #1;
    check_outputs_zero("midreset");
    check("midreset_state", 32'(dbg_state), 32'd0);
    check_writes("midload");
    check("midload_done_cnt", 32'(done_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    nReset = 1'b1;

    // reload restarts at address 0
    clear_obs();
    stream_q = '{8'h5A, 8'hA5, 8'hC3, 8'h3C};
    exp_q    = '{{5'd0, 16'h5AA5}, {5'd1, 16'hC33C}};
    do_start(2, t0);
    send_stream(1'b0);
    wait_done();
    check_writes("reload");
    check("reload_done_cnt", 32'(done_q.size()), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
